// File: rtl/simeck_keysched.sv
// Simeck round-key scheduler: expands a 4-word master key and streams the round keys
// forward or reverse under valid/ready, caching the schedule for replay.
module simeck_keysched #(
   parameter int unsigned DATAW  = 16,
   parameter int unsigned ROUNDS = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [4*DATAW-1:0]        key_in,
   input  logic                      load,
   input  logic                      replay,
   input  logic                      mode,
   input  logic                      rk_ready,
   output logic                      rk_valid,
   output logic [DATAW-1:0]          rk_out,
   output logic [$clog2(ROUNDS)-1:0] rk_idx,
   output logic                      rk_last,
   output logic                      busy,
   output logic                      key_cached
);
   localparam int unsigned IDXW = $clog2(ROUNDS);
   localparam int unsigned LW   = (DATAW == 32) ? 6 : 5;
   localparam int unsigned TAP  = (DATAW == 32) ? 1 : 2;
   localparam logic [IDXW-1:0]  LAST  = IDXW'(ROUNDS - 1);
   localparam logic [DATAW-1:0] CONST = ~DATAW'(3);

   typedef enum logic [1:0] {IDLE, FWD_GEN, EXPAND, REPLAY} state_t;

   state_t            state_q, state_d;
   logic [DATAW-1:0]  t0, t1, t2, t3;
   logic [DATAW-1:0]  t_new, f_t1;
   logic [LW-1:0]     lfsr, lfsr_nx;
   logic [IDXW-1:0]   cnt, wr_addr, rd_next, rd_end;
   logic              mode_q;
   logic              hs, gen, do_load, do_replay;
   logic [DATAW-1:0]  kbuf [ROUNDS];

   function automatic logic [DATAW-1:0] rotl(input logic [DATAW-1:0] x, input int unsigned r);
      rotl = (x << r) | (x >> (DATAW - r));
   endfunction

   assign f_t1    = (t1 & rotl(t1, 5)) ^ rotl(t1, 1);
   assign t_new   = t0 ^ f_t1 ^ CONST ^ DATAW'(lfsr[0]);
   assign lfsr_nx = {lfsr[TAP] ^ lfsr[0], lfsr[LW-1:1]};
   assign hs      = rk_valid & rk_ready;
   assign wr_addr = (state_q == EXPAND) ? cnt : rk_idx;
   assign rd_next = mode_q ? rk_idx - IDXW'(1) : rk_idx + IDXW'(1);
   assign rd_end  = mode_q ? '0 : LAST;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      gen       = 1'b0;
      do_load   = 1'b0;
      do_replay = 1'b0;
      case (state_q)
         IDLE: begin
            if (load) begin
               do_load = 1'b1;
               state_d = mode ? EXPAND : FWD_GEN;
            end else if (replay && key_cached) begin
               do_replay = 1'b1;
               state_d   = REPLAY;
            end
         end
         FWD_GEN: begin
            gen = hs;
            if (hs && rk_idx == LAST) state_d = IDLE;
         end
         EXPAND: begin
            gen = 1'b1;
            if (cnt == LAST) state_d = REPLAY;
         end
         REPLAY: begin
            if (hs && rk_last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Schedule cache; contents are meaningless after reset until rewritten.
   always_ff @(posedge clk) begin
      if (gen) kbuf[wr_addr] <= t0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         t0 <= '0; t1 <= '0; t2 <= '0; t3 <= '0;
         lfsr       <= '1;
         cnt        <= '0;
         mode_q     <= 1'b0;
         rk_valid   <= 1'b0;
         rk_out     <= '0;
         rk_idx     <= '0;
         rk_last    <= 1'b0;
         busy       <= 1'b0;
         key_cached <= 1'b0;
      end else begin
         if (gen) begin
            t0   <= t1;
            t1   <= t2;
            t2   <= t3;
            t3   <= t_new;
            lfsr <= lfsr_nx;
         end
         case (state_q)
            IDLE: begin
               if (do_load) begin
                  t0         <= key_in[0*DATAW +: DATAW];
                  t1         <= key_in[1*DATAW +: DATAW];
                  t2         <= key_in[2*DATAW +: DATAW];
                  t3         <= key_in[3*DATAW +: DATAW];
                  lfsr       <= '1;
                  cnt        <= '0;
                  mode_q     <= mode;
                  busy       <= 1'b1;
                  key_cached <= 1'b0;
                  rk_valid   <= ~mode;
                  rk_out     <= key_in[0 +: DATAW];
                  rk_idx     <= '0;
                  rk_last    <= 1'b0;
               end else if (do_replay) begin
                  mode_q   <= mode;
                  busy     <= 1'b1;
                  rk_valid <= 1'b1;
                  rk_out   <= kbuf[mode ? LAST : '0];
                  rk_idx   <= mode ? LAST : '0;
                  rk_last  <= 1'b0;
               end
            end
            FWD_GEN: begin
               if (hs) begin
                  if (rk_idx == LAST) begin
                     rk_valid   <= 1'b0;
                     rk_last    <= 1'b0;
                     busy       <= 1'b0;
                     key_cached <= 1'b1;
                  end else begin
                     rk_out  <= t1;
                     rk_idx  <= rk_idx + IDXW'(1);
                     rk_last <= (rk_idx + IDXW'(1)) == LAST;
                  end
               end
            end
            EXPAND: begin
               cnt <= cnt + IDXW'(1);
               // Final key is still in t0; forward it so the reverse stream starts without a read bubble.
               if (cnt == LAST) begin
                  key_cached <= 1'b1;
                  rk_valid   <= 1'b1;
                  rk_out     <= t0;
                  rk_idx     <= LAST;
                  rk_last    <= 1'b0;
               end
            end
            REPLAY: begin
               if (hs) begin
                  if (rk_last) begin
                     rk_valid <= 1'b0;
                     rk_last  <= 1'b0;
                     busy     <= 1'b0;
                  end else begin
                     rk_out  <= kbuf[rd_next];
                     rk_idx  <= rd_next;
                     rk_last <= rd_next == rd_end;
                  end
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_simeck_keysched.sv
// Bench for simeck_keysched: Simeck32/64, 48/96 and 64/128 instances driven from a
// vector table and checked against an array-based key-expansion model.
module tb_simeck_keysched;
   localparam int NDUT = 3;
   localparam int DW [NDUT] = '{16, 24, 32};
   localparam int RN [NDUT] = '{32, 36, 44};
   localparam int OP_LOAD = 0, OP_REPLAY = 1, OP_BOTH = 2;
   localparam logic [127:0] K16 = 128'h1918_1110_0908_0100;

   typedef struct {
      int           dut;
      int           op;
      bit           md;
      bit           rnd;
      bit           poke;
      logic [127:0] key;
      int           lat;
   } vec_t;

   logic         clk;
   logic         reset;
   logic [127:0] key_w    [NDUT];
   logic         load_w   [NDUT];
   logic         replay_w [NDUT];
   logic         mode_w   [NDUT];
   logic         ready_w  [NDUT];
   logic         valid_w  [NDUT];
   logic         last_w   [NDUT];
   logic         busy_w   [NDUT];
   logic         cached_w [NDUT];
   logic [31:0]  out_w    [NDUT];
   logic [5:0]   idx_w    [NDUT];
   logic [15:0]  out16;
   logic [23:0]  out24;
   logic [31:0]  out32;
   logic [4:0]   idx16;
   logic [5:0]   idx24, idx32;

   logic [31:0]  mk  [44];
   logic [31:0]  cap [44];
   vec_t         vt  [12];
   int           errors, checks;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   simeck_keysched #(.DATAW(16), .ROUNDS(32)) u16 (
      .clk(clk), .reset(reset), .key_in(key_w[0][63:0]), .load(load_w[0]),
      .replay(replay_w[0]), .mode(mode_w[0]), .rk_ready(ready_w[0]), .rk_valid(valid_w[0]),
      .rk_out(out16), .rk_idx(idx16), .rk_last(last_w[0]), .busy(busy_w[0]),
      .key_cached(cached_w[0]));
   simeck_keysched #(.DATAW(24), .ROUNDS(36)) u24 (
      .clk(clk), .reset(reset), .key_in(key_w[1][95:0]), .load(load_w[1]),
      .replay(replay_w[1]), .mode(mode_w[1]), .rk_ready(ready_w[1]), .rk_valid(valid_w[1]),
      .rk_out(out24), .rk_idx(idx24), .rk_last(last_w[1]), .busy(busy_w[1]),
      .key_cached(cached_w[1]));
   simeck_keysched #(.DATAW(32), .ROUNDS(44)) u32 (
      .clk(clk), .reset(reset), .key_in(key_w[2]), .load(load_w[2]),
      .replay(replay_w[2]), .mode(mode_w[2]), .rk_ready(ready_w[2]), .rk_valid(valid_w[2]),
      .rk_out(out32), .rk_idx(idx32), .rk_last(last_w[2]), .busy(busy_w[2]),
      .key_cached(cached_w[2]));

   assign out_w[0] = 32'(out16);
   assign out_w[1] = 32'(out24);
   assign out_w[2] = out32;
   assign idx_w[0] = 6'(idx16);
   assign idx_w[1] = idx24;
   assign idx_w[2] = idx32;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   function automatic logic [31:0] rotw(input logic [31:0] x, input int r, input int w, input logic [31:0] m);
      rotw = ((x << r) | (x >> (w - r))) & m;
   endfunction

   // Reference expansion: k[i+4] = k[i] ^ f(k[i+1]) ^ C ^ z_i.
   task automatic build_model(input logic [127:0] key, input int w, input int n);
      logic [31:0] m, c, f;
      logic [5:0]  s;
      m = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      c = m & ~32'd3;
      s = (w == 32) ? 6'h3F : 6'h1F;
      for (int i = 0; i < 4; i++) mk[i] = 32'(key >> (i * w)) & m;
      for (int i = 0; i + 4 < n; i++) begin
         f = (mk[i+1] & rotw(mk[i+1], 5, w, m)) ^ rotw(mk[i+1], 1, w, m);
         mk[i+4] = mk[i] ^ f ^ c ^ 32'(s[0]);
         s = (w == 32) ? {s[1] ^ s[0], s[5:1]} : {1'b0, s[2] ^ s[0], s[4:1]};
      end
   endtask

   task automatic run_stream(input int j, input int op, input bit md, input bit rnd,
                             input bit poke, input int exp_lat, input logic [127:0] key);
      int          lat, n, e, cyc;
      logic        stalled;
      logic [31:0] p_out;
      logic [5:0]  p_idx;
      build_model(key, DW[j], RN[j]);
      key_w[j]    = (op == OP_REPLAY) ? ~key : key;
      mode_w[j]   = md;
      load_w[j]   = (op != OP_REPLAY);
      replay_w[j] = (op != OP_LOAD);
      ready_w[j]  = 1'b1;
      @(negedge clk);
      load_w[j]   = 1'b0;
      replay_w[j] = 1'b0;
      lat = 1;
      if (op != OP_REPLAY) chk("cached_clr", 32'(cached_w[j]), 32'd0);
      chk("busy_start", 32'(busy_w[j]), 32'd1);
      while (!valid_w[j] && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      chk("latency", 32'(lat), 32'(exp_lat));
      n = 0; cyc = 0; stalled = 1'b0; p_out = '0; p_idx = '0;
      while (n < RN[j] && cyc < 2000) begin
         if (stalled) begin
            chk("stall_out", out_w[j], p_out);
            chk("stall_idx", 32'(idx_w[j]), 32'(p_idx));
         end
         ready_w[j]  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         load_w[j]   = poke && n == 5;
         replay_w[j] = poke && n == 6;
         if (poke) begin
            mode_w[j] = ~md;
            key_w[j]  = ~key;
         end
         stalled = valid_w[j] && !ready_w[j];
         p_out   = out_w[j];
         p_idx   = idx_w[j];
         if (valid_w[j] && ready_w[j]) begin
            e = md ? RN[j] - 1 - n : n;
            chk("rk_out", out_w[j], mk[e]);
            chk("rk_idx", 32'(idx_w[j]), 32'(e));
            chk("rk_last", 32'(last_w[j]), 32'(n == RN[j] - 1));
            cap[n] = out_w[j];
            n++;
         end else begin
            chk("valid_held", 32'(valid_w[j]), 32'd1);
         end
         @(negedge clk);
         cyc++;
      end
      if (n < RN[j]) begin
         checks++;
         errors++;
         $display("FAIL stream_timeout: dut%0d delivered %0d keys, expected %0d", j, n, RN[j]);
      end
      load_w[j]   = 1'b0;
      replay_w[j] = 1'b0;
      ready_w[j]  = 1'b1;
      chk("busy_end", 32'(busy_w[j]), 32'd0);
      chk("valid_end", 32'(valid_w[j]), 32'd0);
      chk("cached_end", 32'(cached_w[j]), 32'd1);
   endtask

   initial begin
      logic [127:0] k24, k32a, k32b;
      int           cyc;
      errors = 0;
      checks = 0;
      k24  = {32'h0, $urandom, $urandom, $urandom};
      k32a = {$urandom, $urandom, $urandom, $urandom};
      k32b = {$urandom, $urandom, $urandom, $urandom};
      vt[0]  = '{0, OP_LOAD,   1'b0, 1'b0, 1'b0, K16, 1};
      vt[1]  = '{0, OP_LOAD,   1'b1, 1'b0, 1'b0, K16, 33};
      vt[2]  = '{0, OP_LOAD,   1'b0, 1'b1, 1'b1, K16, 1};
      vt[3]  = '{0, OP_REPLAY, 1'b1, 1'b0, 1'b0, K16, 1};
      vt[4]  = '{0, OP_REPLAY, 1'b0, 1'b1, 1'b0, K16, 1};
      vt[5]  = '{0, OP_LOAD,   1'b1, 1'b1, 1'b0, 128'hDEAD_BEEF_0123_4567, 33};
      vt[6]  = '{0, OP_BOTH,   1'b0, 1'b0, 1'b0, 128'h0F1E_2D3C_4B5A_6978, 1};
      vt[7]  = '{1, OP_LOAD,   1'b0, 1'b1, 1'b0, k24, 1};
      vt[8]  = '{1, OP_LOAD,   1'b1, 1'b0, 1'b1, k24, 37};
      vt[9]  = '{2, OP_LOAD,   1'b0, 1'b0, 1'b0, k32a, 1};
      vt[10] = '{2, OP_REPLAY, 1'b1, 1'b1, 1'b0, k32a, 1};
      vt[11] = '{2, OP_LOAD,   1'b1, 1'b1, 1'b0, k32b, 45};

      reset = 1'b1;
      for (int j = 0; j < NDUT; j++) begin
         key_w[j] = '0; load_w[j] = 1'b0; replay_w[j] = 1'b0;
         mode_w[j] = 1'b0; ready_w[j] = 1'b1;
      end
      @(negedge clk);
      @(negedge clk);
      for (int j = 0; j < NDUT; j++) begin
         chk("rst_valid", 32'(valid_w[j]), 32'd0);
         chk("rst_out", out_w[j], 32'd0);
         chk("rst_idx", 32'(idx_w[j]), 32'd0);
         chk("rst_last", 32'(last_w[j]), 32'd0);
         chk("rst_busy", 32'(busy_w[j]), 32'd0);
         chk("rst_cached", 32'(cached_w[j]), 32'd0);
      end
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 12; i++) begin
         run_stream(vt[i].dut, vt[i].op, vt[i].md, vt[i].rnd, vt[i].poke, vt[i].lat, vt[i].key);
         if (i == 0) begin
            chk("k0_const", cap[0], 32'h0100);
            chk("k1_const", cap[1], 32'h0908);
            chk("k2_const", cap[2], 32'h1110);
            chk("k3_const", cap[3], 32'h1918);
            chk("k4_const", cap[4], 32'hEDED);
         end
      end

      // Reset in the middle of a forward stream, then an attempted replay.
      key_w[0] = K16; mode_w[0] = 1'b0; ready_w[0] = 1'b1; load_w[0] = 1'b1;
      @(negedge clk);
      load_w[0] = 1'b0;
      cyc = 0;
      while (idx_w[0] != 6'd10 && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      chk("pre_reset_idx", 32'(idx_w[0]), 32'd10);
      reset = 1'b1;
      #1;
      chk("mid_rst_valid", 32'(valid_w[0]), 32'd0);
      chk("mid_rst_busy", 32'(busy_w[0]), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      chk("post_rst_valid", 32'(valid_w[0]), 32'd0);
      chk("post_rst_busy", 32'(busy_w[0]), 32'd0);
      chk("post_rst_cached", 32'(cached_w[0]), 32'd0);
      chk("post_rst_cached32", 32'(cached_w[2]), 32'd0);
      replay_w[0] = 1'b1;
      @(negedge clk);
      replay_w[0] = 1'b0;
      for (int c = 0; c < 3; c++) begin
         chk("replay_ignored_valid", 32'(valid_w[0]), 32'd0);
         chk("replay_ignored_busy", 32'(busy_w[0]), 32'd0);
         @(negedge clk);
      end
      run_stream(0, OP_LOAD, 1'b1, 1'b1, 1'b1, 33, K16);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
